// File: rtl/channel_row_mapper_pkg.sv
// Shared constants for the scope display row mapper: default vertical
// resolution, FSM encoding and a width helper that never returns zero.
package channel_row_mapper_pkg;

    localparam int VGA_VER_RES = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    function automatic int width_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/channel_row_mapper_seq_divider.sv
// Restoring divider, one quotient bit per cycle. Quotient only; a zero
// divisor finishes on the next cycle with a zero quotient.
module channel_row_mapper_seq_divider
    import channel_row_mapper_pkg::*;
#(
    parameter  int WIDTH = 9,
    localparam int CNTW  = width_min1(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient
);

    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CNTW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;

    // r_dq shifts the dividend out of its top while quotient bits enter at the bottom
    assign w_trial = {r_rem, r_dq[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_qbit  = ~w_diff[WIDTH];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dq   <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_dq   <= (i_divisor == '0) ? '0 : i_dividend;
                r_rem  <= '0;
                r_dvs  <= i_divisor;
                r_cnt  <= CNTW'(WIDTH);
                r_busy <= (i_divisor != '0);
                r_done <= (i_divisor == '0);
            end else if (r_busy) begin
                r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_dq  <= (r_dq << 1) | WIDTH'(w_qbit);
                r_cnt <= r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_dq;

endmodule

// File: rtl/channel_row_mapper.sv
// Per-frame channel band mapper: snapshots the enable mask, lists enabled
// channels, divides the screen into bands and tracks rows incrementally.
module channel_row_mapper
    import channel_row_mapper_pkg::*;
#(
    parameter  int MAX_CHAN_COUNT = 10,
    parameter  int OFFSET         = 0,
    parameter  int VER_RES        = VGA_VER_RES,
    localparam int RW             = width_min1(VER_RES),
    localparam int CW             = width_min1(MAX_CHAN_COUNT),
    localparam int NW             = width_min1(MAX_CHAN_COUNT + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_frame_start,
    input  logic [MAX_CHAN_COUNT-1:0] i_channel_enable,
    input  logic                      i_row_strobe,
    input  logic [RW-1:0]             i_pixel_row,
    output logic                      o_ready,
    output logic                      o_out_valid,
    output logic                      o_is_channel,
    output logic [CW-1:0]             o_channel_number,
    output logic [RW-1:0]             o_channel_row,
    output logic [RW-1:0]             o_channel_height,
    output logic [NW-1:0]             o_channel_count,
    output logic                      o_sync_err
);

    state_t r_state;
    state_t w_state_next;

    logic [MAX_CHAN_COUNT-1:0]         r_snap;
    logic [MAX_CHAN_COUNT-1:0][CW-1:0] r_list;
    logic [CW-1:0]                     r_idx;
    logic [NW-1:0]                     r_count;
    logic [NW-1:0]                     r_count_out;
    logic [RW-1:0]                     r_height;

    logic [NW-1:0] r_slot;
    logic [RW-1:0] r_offs;
    logic [RW-1:0] r_prev;
    logic          r_sync;

    logic          r_out_valid;
    logic          r_is_ch;
    logic [CW-1:0] r_ch_num;
    logic [RW-1:0] r_ch_row;

    logic          w_scan_last;
    logic          w_scan_hit;
    logic [NW-1:0] w_count_final;
    logic          w_div_start;
    logic          w_div_done;
    logic [RW-1:0] w_quotient;

    logic          w_run_strobe;
    logic [RW:0]   w_rel;
    logic          w_row_below;
    logic          w_row_at;
    logic          w_row_next;
    logic          w_band_end;
    logic          w_slot_full;
    logic [NW-1:0] w_slot_n;
    logic [RW-1:0] w_offs_n;
    logic          w_sync_n;
    logic          w_is_ch;
    logic          w_hit;

    assign w_scan_last   = (r_state == ST_SCAN) && (r_idx == CW'(MAX_CHAN_COUNT - 1));
    assign w_scan_hit    = r_snap[r_idx];
    assign w_count_final = r_count + NW'(w_scan_hit);
    assign w_div_start   = w_scan_last && !i_frame_start;

    channel_row_mapper_seq_divider #(
        .WIDTH (RW)
    ) u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_div_start),
        .i_dividend (RW'(VER_RES - OFFSET)),
        .i_divisor  (RW'(w_count_final)),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   ;
            ST_SCAN:   if (w_scan_last) w_state_next = ST_DIVIDE;
            ST_DIVIDE: if (w_div_done)  w_state_next = ST_RUN;
            ST_RUN:    ;
            default:   w_state_next = ST_IDLE;
        endcase
        if (i_frame_start) w_state_next = ST_SCAN;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_snap      <= '0;
            r_list      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_count_out <= '0;
            r_height    <= '0;
        end else if (i_frame_start) begin
            r_snap  <= i_channel_enable;
            r_list  <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else if (r_state == ST_SCAN) begin
            if (w_scan_hit) begin
                r_list[r_count[CW-1:0]] <= r_idx;
                r_count                 <= w_count_final;
            end
            if (!w_scan_last) r_idx <= r_idx + CW'(1);
        end else if ((r_state == ST_DIVIDE) && w_div_done) begin
            r_height    <= w_quotient;
            r_count_out <= r_count;
        end
    end

    // Widened subtract gives below/at-OFFSET tests without constant compares
    assign w_run_strobe = i_row_strobe && (r_state == ST_RUN) && !i_frame_start;
    assign w_rel        = {1'b0, i_pixel_row} - (RW + 1)'(OFFSET);
    assign w_row_below  = w_rel[RW];
    assign w_row_at     = (w_rel == '0);
    assign w_row_next   = (i_pixel_row == r_prev + RW'(1));
    assign w_band_end   = (r_offs == r_height - RW'(1));
    assign w_slot_full  = (r_slot == r_count);

    always_comb begin
        w_slot_n = r_slot;
        w_offs_n = r_offs;
        w_sync_n = r_sync;
        if (w_row_below || w_row_at) begin
            w_slot_n = '0;
            w_offs_n = '0;
        end else if (w_row_next) begin
            if (w_band_end) begin
                w_offs_n = '0;
                if (!w_slot_full) w_slot_n = r_slot + NW'(1);
            end else begin
                w_offs_n = r_offs + RW'(1);
            end
        end else begin
            w_sync_n = 1'b1;
        end
        w_is_ch = (r_count != '0) && (w_slot_n < r_count) && !w_sync_n && !w_row_below;
    end

    assign w_hit = w_run_strobe && w_is_ch;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_slot <= '0;
            r_offs <= '0;
            r_prev <= '0;
            r_sync <= 1'b0;
        end else if (i_frame_start) begin
            r_slot <= '0;
            r_offs <= '0;
            r_prev <= '0;
            r_sync <= 1'b0;
        end else if (w_run_strobe) begin
            r_slot <= w_slot_n;
            r_offs <= w_offs_n;
            r_prev <= i_pixel_row;
            r_sync <= w_sync_n;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_is_ch     <= 1'b0;
            r_ch_num    <= '0;
            r_ch_row    <= '0;
        end else begin
            r_out_valid <= i_row_strobe;
            if (i_row_strobe) begin
                r_is_ch  <= w_hit;
                r_ch_num <= w_hit ? r_list[w_slot_n[CW-1:0]] : '0;
                r_ch_row <= w_hit ? w_offs_n : '0;
            end
        end
    end

    assign o_ready          = (r_state == ST_RUN);
    assign o_out_valid      = r_out_valid;
    assign o_is_channel     = r_is_ch;
    assign o_channel_number = r_ch_num;
    assign o_channel_row    = r_ch_row;
    assign o_channel_height = r_height;
    assign o_channel_count  = r_count_out;
    assign o_sync_err       = r_sync;

endmodule

// File: tb/tb_channel_row_mapper.sv
// Randomized bench for channel_row_mapper: two instances (OFFSET 0 and 20)
// share stimulus and are checked against an arithmetic band model.
module tb_channel_row_mapper;

    localparam int MAXC = 10;
    localparam int VRES = 480;
    localparam int RW   = 9;
    localparam int CW   = 4;
    localparam int NW   = 4;
    localparam int SETUP_BOUND = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fs  = 1'b0;
    logic            rs  = 1'b0;
    logic [MAXC-1:0] en  = '0;
    logic [RW-1:0]   prow = '0;

    logic [1:0]          rdy, ov, isc, serr;
    logic [1:0][CW-1:0]  chn;
    logic [1:0][RW-1:0]  crow, hgt;
    logic [1:0][NW-1:0]  cnt;

    int n_total = 0;
    int n_bad   = 0;
    int offs_of[2] = '{0, 20};
    int m_mask;
    int m_prev[2];
    bit m_sync[2];

    always #5 clk = ~clk;

    channel_row_mapper #(.MAX_CHAN_COUNT(MAXC), .OFFSET(0), .VER_RES(VRES)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_frame_start(fs), .i_channel_enable(en),
        .i_row_strobe(rs), .i_pixel_row(prow),
        .o_ready(rdy[0]), .o_out_valid(ov[0]), .o_is_channel(isc[0]),
        .o_channel_number(chn[0]), .o_channel_row(crow[0]),
        .o_channel_height(hgt[0]), .o_channel_count(cnt[0]), .o_sync_err(serr[0])
    );

    channel_row_mapper #(.MAX_CHAN_COUNT(MAXC), .OFFSET(20), .VER_RES(VRES)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_frame_start(fs), .i_channel_enable(en),
        .i_row_strobe(rs), .i_pixel_row(prow),
        .o_ready(rdy[1]), .o_out_valid(ov[1]), .o_is_channel(isc[1]),
        .o_channel_number(chn[1]), .o_channel_row(crow[1]),
        .o_channel_height(hgt[1]), .o_channel_count(cnt[1]), .o_sync_err(serr[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    function automatic int popc(input int m);
        int c = 0;
        for (int i = 0; i < MAXC; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int nth_set(input int m, input int k);
        int left = k;
        for (int i = 0; i < MAXC; i++) begin
            if (m[i]) begin
                if (left == 0) return i;
                left--;
            end
        end
        return 0;
    endfunction

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d ready", tag, d),  32'(rdy[d]),  0);
            chk($sformatf("%s d%0d valid", tag, d),  32'(ov[d]),   0);
            chk($sformatf("%s d%0d is_ch", tag, d),  32'(isc[d]),  0);
            chk($sformatf("%s d%0d ch", tag, d),     32'(chn[d]),  0);
            chk($sformatf("%s d%0d row", tag, d),    32'(crow[d]), 0);
            chk($sformatf("%s d%0d height", tag, d), 32'(hgt[d]),  0);
            chk($sformatf("%s d%0d count", tag, d),  32'(cnt[d]),  0);
            chk($sformatf("%s d%0d sync", tag, d),   32'(serr[d]), 0);
        end
    endtask

    task automatic strobe_row(input int r);
        int off, c, h, k, e_is, e_ch, e_row;
        @(negedge clk);
        rs   = 1'b1;
        prow = RW'(r);
        @(posedge clk);
        #1;
        rs = 1'b0;
        for (int d = 0; d < 2; d++) begin
            off = offs_of[d];
            if (r > off && r != m_prev[d] + 1) m_sync[d] = 1'b1;
            m_prev[d] = r;
            c = popc(m_mask);
            h = (c != 0) ? (VRES - off) / c : 0;
            e_is = 0; e_ch = 0; e_row = 0;
            if (!m_sync[d] && r >= off && c != 0) begin
                k = (r - off) / h;
                if (k < c) begin
                    e_is  = 1;
                    e_ch  = nth_set(m_mask, k);
                    e_row = (r - off) % h;
                end
            end
            chk($sformatf("d%0d r%0d valid", d, r), 32'(ov[d]),   1);
            chk($sformatf("d%0d r%0d is_ch", d, r), 32'(isc[d]),  32'(e_is));
            chk($sformatf("d%0d r%0d ch", d, r),    32'(chn[d]),  32'(e_ch));
            chk($sformatf("d%0d r%0d crow", d, r),  32'(crow[d]), 32'(e_row));
            chk($sformatf("d%0d r%0d sync", d, r),  32'(serr[d]), 32'(m_sync[d]));
        end
    endtask

    task automatic start_frame(input int mask, input bit coinc);
        int n;
        @(negedge clk);
        fs   = 1'b1;
        en   = MAXC'(mask);
        rs   = coinc;
        prow = '0;
        @(posedge clk);
        #1;
        fs = 1'b0;
        rs = 1'b0;
        m_mask = mask;
        m_prev = '{0, 0};
        m_sync = '{1'b0, 1'b0};
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("fs d%0d ready_low", d), 32'(rdy[d]), 0);
            chk($sformatf("fs d%0d valid", d), 32'(ov[d]), 32'(coinc));
            if (coinc) chk($sformatf("fs d%0d coinc_is_ch", d), 32'(isc[d]), 0);
        end
        // a strobe during setup still produces out_valid, never a channel
        @(negedge clk);
        rs   = 1'b1;
        prow = RW'(7);
        @(posedge clk);
        #1;
        rs = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("setup d%0d valid", d), 32'(ov[d]),  1);
            chk($sformatf("setup d%0d is_ch", d), 32'(isc[d]), 0);
            chk($sformatf("setup d%0d ready", d), 32'(rdy[d]), 0);
        end
        n = 0;
        while (rdy != 2'b11 && n < SETUP_BOUND) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("setup_done", 32'(rdy), 32'(2'b11));
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d count", d), 32'(cnt[d]), 32'(popc(mask)));
            chk($sformatf("d%0d height", d), 32'(hgt[d]),
                (popc(mask) != 0) ? 32'((VRES - offs_of[d]) / popc(mask)) : 0);
        end
    endtask

    task automatic run_rows(input int skip, input int change_at);
        for (int r = 0; r < VRES; r++) begin
            if (r == change_at) en = MAXC'($urandom);
            if (r != skip) strobe_row(r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mask, skip;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // two bands, enable disturbed mid-frame without frame_start
        start_frame(10'b0000000101, 1'b0);
        run_rows(-1, 240);
        // all channels, strobe coincident with frame_start
        start_frame(10'b1111111111, 1'b1);
        run_rows(-1, -1);
        start_frame(10'b0010010010, 1'b0);
        run_rows(-1, -1);
        start_frame(0, 1'b0);
        run_rows(-1, -1);

        // reset while the divider is running
        @(negedge clk);
        fs = 1'b1;
        en = 10'h2AA;
        @(posedge clk);
        #1;
        fs = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_div_reset");
        @(negedge clk);
        rst = 1'b0;

        // skipped row 101 breaks sync until the next frame
        start_frame(10'h2AA, 1'b0);
        run_rows(101, -1);

        repeat (6) begin
            mask = int'($urandom_range(0, 1023));
            skip = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 478)) : -1;
            start_frame(mask, $urandom_range(0, 1) != 0);
            run_rows(skip, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
